// File: rtl/sigmoid_wb_buffer_if.sv
// Bundle of the upstream sigmoid result group, register-file write port and status
// signals of the sigmoid writeback buffer; slave is the buffer, master drives it.
interface sigmoid_wb_buffer_if;
  logic        reg_wen_o;
  logic [3:0]  word_sel_o;
  logic [4:0]  index_o;
  logic [31:0] result_0;
  logic [31:0] result_1;
  logic [31:0] result_2;
  logic [31:0] result_3;
  logic        error_0;
  logic        error_1;
  logic        error_2;
  logic        error_3;
  logic        empty;
  logic        rf_grant;
  logic        err_clr;
  logic        rf_wen;
  logic [4:0]  rf_index;
  logic [3:0]  rf_word_sel;
  logic [31:0] rf_wdata_0;
  logic [31:0] rf_wdata_1;
  logic [31:0] rf_wdata_2;
  logic [31:0] rf_wdata_3;
  logic        stall_o;
  logic [3:0]  err_lane;
  logic        overflow;
  logic        idle;

  modport master (
    output reg_wen_o, word_sel_o, index_o, result_0, result_1, result_2, result_3,
           error_0, error_1, error_2, error_3, empty, rf_grant, err_clr,
    input  rf_wen, rf_index, rf_word_sel, rf_wdata_0, rf_wdata_1, rf_wdata_2, rf_wdata_3,
           stall_o, err_lane, overflow, idle
  );

  modport slave (
    input  reg_wen_o, word_sel_o, index_o, result_0, result_1, result_2, result_3,
           error_0, error_1, error_2, error_3, empty, rf_grant, err_clr,
    output rf_wen, rf_index, rf_word_sel, rf_wdata_0, rf_wdata_1, rf_wdata_2, rf_wdata_3,
           stall_o, err_lane, overflow, idle
  );
endinterface

// File: rtl/sigmoid_wb_buffer.sv
// Writeback FIFO between the four-lane sigmoid unit and the register-file write port.
// Optional macro SIGMOID_WB_BYPASS_EN adds a zero-latency path when the FIFO is empty.
module sigmoid_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int SKID  = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  sigmoid_wb_buffer_if.slave  wb
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] STALL_CNT = (AW + 1)'(DEPTH - SKID);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [4:0]        idx_q  [DEPTH];
  logic [4:0]        idx_d  [DEPTH];
  logic [3:0]        sel_q  [DEPTH];
  logic [3:0]        sel_d  [DEPTH];
  logic [3:0][31:0]  data_q [DEPTH];
  logic [3:0][31:0]  data_d [DEPTH];
  logic [3:0]        err_lane_q, err_lane_d;
  logic              overflow_q, overflow_d;

  logic [3:0][31:0]  in_data_s;
  logic [3:0]        in_err_s;
  logic              push_s;
  logic              fifo_empty_s;
  logic              full_s;
  logic              byp_s;
  logic              pop_s;
  logic              wr_en_s;
  logic              drop_s;

  // Push/pop/drop decisions for the current cycle
  always_comb begin
    in_data_s    = {wb.result_3, wb.result_2, wb.result_1, wb.result_0};
    in_err_s     = {wb.error_3, wb.error_2, wb.error_1, wb.error_0};
    push_s       = wb.reg_wen_o && (wb.word_sel_o != 4'b0000);
    fifo_empty_s = (cnt_q == '0);
    full_s       = (cnt_q == FULL_CNT);
`ifdef SIGMOID_WB_BYPASS_EN
    byp_s        = fifo_empty_s && push_s;
`else
    byp_s        = 1'b0;
`endif
    pop_s        = !fifo_empty_s && wb.rf_grant;
    // A bypassed group granted in the same cycle never enters the FIFO.
    wr_en_s      = push_s && !(byp_s && wb.rf_grant) && (!full_s || pop_s);
    drop_s       = push_s && full_s && !pop_s;
  end

  // Next-state for pointers, occupancy, storage and sticky status
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    data_d     = data_q;
    if (wr_en_s) begin
      idx_d[wr_ptr_q]  = wb.index_o;
      sel_d[wr_ptr_q]  = wb.word_sel_o;
      data_d[wr_ptr_q] = in_data_s;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d         = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    // Set beats clear when both land in the same cycle.
    err_lane_d = (wb.err_clr ? 4'b0000 : err_lane_q) |
                 (push_s ? (in_err_s & wb.word_sel_o) : 4'b0000);
    overflow_d = (wb.err_clr ? 1'b0 : overflow_q) | drop_s;
  end

  // State registers, flushed asynchronously by nRST
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_lane_q <= 4'b0000;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i]  <= 5'd0;
        sel_q[i]  <= 4'd0;
        data_q[i] <= {4{32'd0}};
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_lane_q <= err_lane_d;
      overflow_q <= overflow_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
    end
  end

  // Register-file port and status outputs
  always_comb begin
    wb.rf_wen   = !fifo_empty_s || byp_s;
    wb.stall_o  = (cnt_q >= STALL_CNT);
    wb.err_lane = err_lane_q;
    wb.overflow = overflow_q;
    wb.idle     = fifo_empty_s && wb.empty;
    if (byp_s) begin
      wb.rf_index    = wb.index_o;
      wb.rf_word_sel = wb.word_sel_o;
      wb.rf_wdata_0  = in_data_s[0];
      wb.rf_wdata_1  = in_data_s[1];
      wb.rf_wdata_2  = in_data_s[2];
      wb.rf_wdata_3  = in_data_s[3];
    end else if (!fifo_empty_s) begin
      wb.rf_index    = idx_q[rd_ptr_q];
      wb.rf_word_sel = sel_q[rd_ptr_q];
      wb.rf_wdata_0  = data_q[rd_ptr_q][0];
      wb.rf_wdata_1  = data_q[rd_ptr_q][1];
      wb.rf_wdata_2  = data_q[rd_ptr_q][2];
      wb.rf_wdata_3  = data_q[rd_ptr_q][3];
    end else begin
      wb.rf_index    = 5'd0;
      wb.rf_word_sel = 4'd0;
      wb.rf_wdata_0  = 32'd0;
      wb.rf_wdata_1  = 32'd0;
      wb.rf_wdata_2  = 32'd0;
      wb.rf_wdata_3  = 32'd0;
    end
  end

endmodule

// File: tb/tb_sigmoid_wb_buffer.sv
// Scoreboard bench for sigmoid_wb_buffer: stimulus queues expected groups, a negedge
// monitor compares every granted write and the status outputs against a queue model.
module tb_sigmoid_wb_buffer;
  localparam int DEPTH = 4;
  localparam int SKID  = 2;
`ifdef SIGMOID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]       idx;
    logic [3:0]       sel;
    logic [3:0][31:0] d;
  } grp_t;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  sigmoid_wb_buffer_if wb ();
  sigmoid_wb_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (.CLK(CLK), .nRST(nRST), .wb(wb));

  grp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] m_err = 4'b0000;
  logic       m_ovf = 1'b0;
  bit         new_c = 1'b0;
  bit         mon_en = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: status against the model every cycle, data on every granted write
  always @(negedge CLK) begin : mon
    int   cnt;
    grp_t g;
    if (mon_en && nRST) begin
      cnt = exp_q.size() - (new_c ? 1 : 0);
      chk("rf_wen",   64'(wb.rf_wen),   64'((cnt > 0) || (BYP && new_c)));
      chk("stall_o",  64'(wb.stall_o),  64'(cnt >= DEPTH - SKID));
      chk("idle",     64'(wb.idle),     64'((cnt == 0) && wb.empty));
      chk("err_lane", 64'(wb.err_lane), 64'(m_err));
      chk("overflow", 64'(wb.overflow), 64'(m_ovf));
      if (wb.rf_wen && wb.rf_grant) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          g = exp_q.pop_front();
          chk("rf_index",    64'(wb.rf_index),    64'(g.idx));
          chk("rf_word_sel", 64'(wb.rf_word_sel), 64'(g.sel));
          if (g.sel[0]) chk("rf_wdata_0", 64'(wb.rf_wdata_0), 64'(g.d[0]));
          if (g.sel[1]) chk("rf_wdata_1", 64'(wb.rf_wdata_1), 64'(g.d[1]));
          if (g.sel[2]) chk("rf_wdata_2", 64'(wb.rf_wdata_2), 64'(g.d[2]));
          if (g.sel[3]) chk("rf_wdata_3", 64'(wb.rf_wdata_3), 64'(g.d[3]));
        end
      end
    end
  end

  // One clock of stimulus; the expected group is queued when it will be accepted
  task automatic step(input logic wen, input logic [3:0] sel, input logic [4:0] idx,
                      input logic [31:0] d0, input logic [3:0] err, input logic grant,
                      input logic clr);
    grp_t g;
    bit   push;
    bit   drop;
    g.idx  = idx;
    g.sel  = sel;
    g.d[0] = d0;
    g.d[1] = $urandom;
    g.d[2] = $urandom;
    g.d[3] = $urandom;
    wb.reg_wen_o  = wen;
    wb.word_sel_o = sel;
    wb.index_o    = idx;
    wb.result_0   = g.d[0];
    wb.result_1   = g.d[1];
    wb.result_2   = g.d[2];
    wb.result_3   = g.d[3];
    wb.error_0    = err[0];
    wb.error_1    = err[1];
    wb.error_2    = err[2];
    wb.error_3    = err[3];
    wb.rf_grant   = grant;
    wb.err_clr    = clr;
    wb.empty      = 1'($urandom_range(0, 1));
    push  = wen && (sel != 4'b0000);
    drop  = push && (exp_q.size() == DEPTH) && !grant;
    new_c = push && !drop;
    if (new_c) exp_q.push_back(g);
    @(posedge CLK);
    m_err = (clr ? 4'b0000 : m_err) | (push ? (err & sel) : 4'b0000);
    m_ovf = (clr ? 1'b0 : m_ovf) | drop;
    new_c = 1'b0;
    #1;
  endtask

  task automatic idle_steps(input int n, input logic grant);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 5'd0, 32'd0, 4'b0000, grant, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rf_wen"},   64'(wb.rf_wen),      64'd0);
    chk({tag, "_rf_index"}, 64'(wb.rf_index),    64'd0);
    chk({tag, "_rf_sel"},   64'(wb.rf_word_sel), 64'd0);
    chk({tag, "_wdata"},    64'(wb.rf_wdata_0 | wb.rf_wdata_1 | wb.rf_wdata_2 | wb.rf_wdata_3), 64'd0);
    chk({tag, "_stall"},    64'(wb.stall_o),     64'd0);
    chk({tag, "_err_lane"}, 64'(wb.err_lane),    64'd0);
    chk({tag, "_overflow"}, 64'(wb.overflow),    64'd0);
    chk({tag, "_idle"},     64'(wb.idle),        64'(wb.empty));
  endtask

  initial begin
    wb.reg_wen_o = 1'b0; wb.word_sel_o = 4'b0000; wb.index_o = 5'd0;
    wb.result_0 = 32'd0; wb.result_1 = 32'd0; wb.result_2 = 32'd0; wb.result_3 = 32'd0;
    wb.error_0 = 1'b0; wb.error_1 = 1'b0; wb.error_2 = 1'b0; wb.error_3 = 1'b0;
    wb.empty = 1'b1; wb.rf_grant = 1'b0; wb.err_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_values("reset");
    nRST   = 1'b1;
    mon_en = 1'b1;

    // Single group, granted as soon as it is presented
    step(1'b1, 4'b0101, 5'd3, 32'h3F000000, 4'b0000, 1'b1, 1'b0);
    idle_steps(3, 1'b1);

    // Fill to DEPTH, one more push overflows, then drain in order
    for (int i = 1; i <= 5; i++)
      step(1'b1, 4'b1111, 5'(i), 32'(i), 4'b0000, 1'b0, 1'b0);
    idle_steps(6, 1'b1);
    step(1'b0, 4'b0000, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'b0011, 5'(8 + i), 32'(100 + i), 4'b0000, 1'b0, 1'b0);
    step(1'b1, 4'b1000, 5'd20, 32'hCAFE0000, 4'b0000, 1'b1, 1'b0);
    idle_steps(6, 1'b1);

    // Error flags: selected lane sets, unselected lane ignored, set beats clear
    step(1'b1, 4'b0100, 5'd1, 32'd7, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 5'd2, 32'd8, 4'b0010, 1'b1, 1'b0);
    step(1'b1, 4'b1000, 5'd4, 32'd9, 4'b1000, 1'b1, 1'b1);
    idle_steps(2, 1'b1);
    chk("err_after_clr_set", 64'(wb.err_lane), 64'h8);

    // Discarded group with no lane selected
    step(1'b1, 4'b0000, 5'd9, 32'd1, 4'b1111, 1'b1, 1'b0);
    idle_steps(2, 1'b1);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'b0110, 5'(16 + i), 32'(i), 4'b0000, 1'b0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_q.delete();
    m_err = 4'b0000;
    m_ovf = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    idle_steps(4, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 5'($urandom),
           $urandom, 4'($urandom), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 15) == 0));

    idle_steps(DEPTH + 4, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
